rx_8b9b_frame_buffer: RTL and testbench
=======================================

Name: rx_8b9b_frame_buffer

Overview:
- Downstream consumer of the 8b9b oversampling receiver.
- Collects the received words (word/word_write/frame_complete) into a circular buffer and releases each frame to the fabric only once it is complete and valid.
- Aborts oversized, overflowing or stalled frames atomically, so downstream logic never sees a partial frame.
- Output is a valid/ready stream with an end-of-frame flag.

Parameters:
WORD_WIDTH, 8, width of received word; matches receiver word width
ADDR_WIDTH, 9, buffer address width; DEPTH = 2**ADDR_WIDTH words
MAX_FRAME, 256, maximum words per frame; a longer frame is dropped
TIMEOUT, 64, idle clk cycles inside a frame (no word_write) before the frame is aborted
CNT_WIDTH, 16, width of the statistics counters

Ports:
clk  input  1  single clock, same domain as the receiver word output
async_reset_n  input  1  asynchronous active-low reset
word_in  input  WORD_WIDTH  received word, qualified by word_write
word_write  input  1  one-cycle strobe: word_in valid
frame_complete  input  1  asserted in the same cycle as the final word_write of a frame
m_data  output  WORD_WIDTH  output word
m_last  output  1  m_data is the final word of its frame
m_valid  output  1  m_data/m_last valid
m_ready  input  1  consumer accepts when m_valid & m_ready
fill_level  output  ADDR_WIDTH+1  words written (committed + in progress) not yet read
frames_ok  output  CNT_WIDTH  committed-frame count, saturating
frames_dropped  output  CNT_WIDTH  dropped-frame count, saturating
drop_pulse  output  1  one-cycle pulse on each drop

Behaviour:
- Reset (async assert, sync release): every output 0, all pointers 0, state IDLE, buffer contents don't-care. Reset mid-frame discards everything.
- Storage entries are WORD_WIDTH+1 bits wide: {last, word}. last is set only on the word written with frame_complete.
- Pointers are ADDR_WIDTH+1 bits, wrapping naturally:
  - wr_ptr: tentative write pointer.
  - commit_ptr: end of the last complete frame.
  - rd_ptr: read pointer.
  - fill_level = wr_ptr - rd_ptr.
- Full: fill_level == DEPTH. A read in the same cycle does not count as free space.
- Frame state machine, states IDLE / RECV / DISCARD; len counts words in the current frame; idle_cnt counts cycles since the last word.
  - IDLE, word_write:
    - Store the word, len = 1.
    - If frame_complete also asserted: commit, stay in IDLE.
    - Otherwise go to RECV.
    - If the buffer is full: drop instead, go to DISCARD, or stay in IDLE if frame_complete.
  - RECV, word_write:
    - If full, or len == MAX_FRAME: drop.
      - Drop means wr_ptr <= commit_ptr, frames_dropped++, drop_pulse.
      - Next state is IDLE if frame_complete in that cycle, else DISCARD.
    - Otherwise store the word, len++, clear idle_cnt.
    - If frame_complete (and no drop): commit (commit_ptr <= wr_ptr+1, frames_ok++), go to IDLE.
  - RECV, no word_write: idle_cnt++. When idle_cnt reaches TIMEOUT-1: drop, go to IDLE.
  - DISCARD:
    - Ignore words.
    - frame_complete goes to IDLE.
    - TIMEOUT idle cycles go to IDLE without a second drop count.
- frame_complete with no word_write: ignored in every state.
- Output stage: a single registered stage.
  - Loads from buffer[rd_ptr] when rd_ptr != commit_ptr and (!m_valid or m_ready); rd_ptr increments on each load.
  - Only committed words are ever readable.
  - Latency: frame_complete in cycle T puts the first word on m_valid in cycle T+2, given m_valid was low and the buffer was empty before the frame.
  - Back-to-back reads at full rate while m_ready is held high.
- A drop never touches data below commit_ptr. Frames already committed drain normally.
- Counters saturate at all-ones.

Decomposition:
- Package rx_8b9b_pkg holds:
  - the frame state enum (IDLE/RECV/DISCARD);
  - the pointer-width constant derivation;
  - the entry layout constants (LAST_BIT index, ENTRY_WIDTH = WORD_WIDTH+1).
- One sub-module: frame_buffer_ram.
  - Simple dual-port RAM, DEPTH x ENTRY_WIDTH.
  - Synchronous write, synchronous read with a read-address input.
  - Inferred, no vendor primitive.

Test Plan:
- Frame 0xA5,0x3C (frame_complete with 0x3C) -> in cycle T+2, m_valid=1, m_data=0xA5, m_last=0; next word 0x3C with m_last=1; frames_ok=1.
- Single-word frame 0x7E with word_write and frame_complete together in IDLE -> one output word 0x7E, m_last=1; state remains IDLE.
- MAX_FRAME=4, frame of 6 words ending with frame_complete -> drop_pulse on the 5th word; no output words; frames_dropped=1; a following 2-word frame is delivered intact.
- Frame of 3 words then silence for TIMEOUT cycles -> drop, fill_level returns to the prior value; a subsequent frame is delivered correctly.
- ADDR_WIDTH=3, m_ready=0: write 8-word frame (commits, fill=8), then a new frame -> dropped at its first word; after m_ready=1, the 8 words drain with m_last only on the 8th.
- async_reset_n pulsed low mid-frame with committed data pending -> m_valid=0, fill_level=0, counters 0; the next frame is received normally.

Source files
------------

// File: rtl/rx_8b9b_pkg.sv
// Shared definitions for the 8b9b receive frame buffer: frame states,
// pointer width derivation and the {last, word} storage entry layout.
package rx_8b9b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } frame_state_e;

  // One extra pointer bit lets full and empty be told apart after wrapping.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int entry_width(input int word_width);
    return word_width + 1;
  endfunction

  function automatic int last_bit(input int word_width);
    return word_width;
  endfunction

endpackage

// File: rtl/rx_8b9b_frame_buffer_ram.sv
// Simple dual-port frame store: synchronous write, registered read with
// a read enable so the read register holds its word while stalled.
module frame_buffer_ram
  import rx_8b9b_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int ENTRY_WIDTH = entry_width(8)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [ENTRY_WIDTH-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [ENTRY_WIDTH-1:0] rd_data
);

  logic [ENTRY_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_8b9b_frame_buffer.sv
// Frame buffer behind the 8b9b receiver: stores words tentatively, commits
// whole frames, aborts bad ones atomically and streams committed words out.
module rx_8b9b_frame_buffer
  import rx_8b9b_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_FRAME  = 256,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_write,
  input  logic                  frame_complete,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic [CNT_WIDTH-1:0]  frames_ok,
  output logic [CNT_WIDTH-1:0]  frames_dropped,
  output logic                  drop_pulse
);

  localparam int PTR_W   = ptr_width(ADDR_WIDTH);
  localparam int ENTRY_W = entry_width(WORD_WIDTH);
  localparam int LAST_B  = last_bit(WORD_WIDTH);
  localparam int LEN_W   = $clog2(MAX_FRAME + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);

  localparam logic [PTR_W-1:0]  DEPTH_P  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_FRAME);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  frame_state_e      state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, commit_ptr, rd_ptr;
  logic [LEN_W-1:0]  len;
  logic [IDLE_W-1:0] idle_cnt;
  logic              full;
  logic              wr_en_p0, commit_p0, drop_p0;
  logic              load_p0, vld_p1;
  logic [ENTRY_W-1:0] wr_entry_p0, rd_entry_p1;

  assign fill_level  = wr_ptr - rd_ptr;
  assign full        = (fill_level == DEPTH_P);
  assign wr_entry_p0 = {frame_complete, word_in};

  // Stage p0: frame state machine decides store / commit / drop
  always_comb begin
    state_nxt = state;
    wr_en_p0  = 1'b0;
    commit_p0 = 1'b0;
    drop_p0   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (word_write) begin
          if (full) begin
            drop_p0   = 1'b1;
            state_nxt = frame_complete ? ST_IDLE : ST_DISCARD;
          end else begin
            wr_en_p0  = 1'b1;
            commit_p0 = frame_complete;
            state_nxt = frame_complete ? ST_IDLE : ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (word_write) begin
          if (full || (len == MAX_LEN)) begin
            drop_p0   = 1'b1;
            state_nxt = frame_complete ? ST_IDLE : ST_DISCARD;
          end else begin
            wr_en_p0  = 1'b1;
            commit_p0 = frame_complete;
            state_nxt = frame_complete ? ST_IDLE : ST_RECV;
          end
        end else if (idle_cnt == IDLE_LIM) begin
          drop_p0   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (word_write) begin
          if (frame_complete) state_nxt = ST_IDLE;
        end else if (idle_cnt == IDLE_LIM) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      len            <= '0;
      idle_cnt       <= '0;
      frames_ok      <= '0;
      frames_dropped <= '0;
      drop_pulse     <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop_pulse <= drop_p0;
      if (drop_p0) wr_ptr <= commit_ptr;
      else if (wr_en_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (commit_p0) begin
        commit_ptr <= wr_ptr + PTR_W'(1);
        frames_ok  <= sat_inc(frames_ok);
      end
      if (drop_p0) frames_dropped <= sat_inc(frames_dropped);
      if (wr_en_p0) len <= (state == ST_IDLE) ? LEN_W'(1) : len + LEN_W'(1);
      // Idle timer only runs while sitting inside a frame without words
      if (word_write || (state == ST_IDLE) || (state_nxt != state))
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  frame_buffer_ram #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .ENTRY_WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_p0),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_entry_p0),
    .rd_en   (load_p0),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (rd_entry_p1)
  );

  // Stage p1: RAM read register doubles as the output holding register
  assign load_p0 = (rd_ptr != commit_ptr) && (!vld_p1 || m_ready);

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      rd_ptr <= '0;
      vld_p1 <= 1'b0;
    end else if (load_p0) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
      vld_p1 <= 1'b1;
    end else if (m_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign m_valid = vld_p1;
  assign m_data  = vld_p1 ? rd_entry_p1[WORD_WIDTH-1:0] : '0;
  assign m_last  = vld_p1 & rd_entry_p1[LAST_B];

endmodule

// File: tb/tb_rx_8b9b_frame_buffer.sv
// Directed bench for rx_8b9b_frame_buffer using two differently sized
// instances that share one word stream, steered by sel_b.
module tb_rx_8b9b_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] w_word;
  logic       w_write, w_fc, sel_b;
  logic       rdy_a, rdy_b;
  logic       wr_a, wr_b;

  assign wr_a = w_write & ~sel_b;
  assign wr_b = w_write & sel_b;

  logic [7:0]  a_data, b_data;
  logic        a_last, b_last, a_valid, b_valid, a_dp, b_dp;
  logic [3:0]  a_fill;
  logic [4:0]  b_fill;
  logic [15:0] a_ok, b_ok, a_drop, b_drop;

  int checks   = 0;
  int failures = 0;

  rx_8b9b_frame_buffer #(
    .WORD_WIDTH(8), .ADDR_WIDTH(3), .MAX_FRAME(16), .TIMEOUT(8), .CNT_WIDTH(16)
  ) u_a (
    .clk(clk), .async_reset_n(rst_n), .word_in(w_word), .word_write(wr_a),
    .frame_complete(w_fc), .m_data(a_data), .m_last(a_last), .m_valid(a_valid),
    .m_ready(rdy_a), .fill_level(a_fill), .frames_ok(a_ok),
    .frames_dropped(a_drop), .drop_pulse(a_dp)
  );

  rx_8b9b_frame_buffer #(
    .WORD_WIDTH(8), .ADDR_WIDTH(4), .MAX_FRAME(4), .TIMEOUT(8), .CNT_WIDTH(16)
  ) u_b (
    .clk(clk), .async_reset_n(rst_n), .word_in(w_word), .word_write(wr_b),
    .frame_complete(w_fc), .m_data(b_data), .m_last(b_last), .m_valid(b_valid),
    .m_ready(rdy_b), .fill_level(b_fill), .frames_ok(b_ok),
    .frames_dropped(b_drop), .drop_pulse(b_dp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input logic fc);
    w_word  = w;
    w_fc    = fc;
    w_write = 1'b1;
    tick();
    w_write = 1'b0;
    w_fc    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; w_word = 8'h00; w_write = 1'b0; w_fc = 1'b0;
    sel_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b1;
    repeat (3) tick();
    chk("rst_a_valid", 32'(a_valid), 32'h0);
    chk("rst_a_fill",  32'(a_fill),  32'h0);
    chk("rst_b_valid", 32'(b_valid), 32'h0);
    chk("rst_b_data",  32'(b_data),  32'h0);
    chk("rst_b_ok",    32'(b_ok),    32'h0);
    chk("rst_b_dp",    32'(b_dp),    32'h0);
    rst_n = 1'b1;
    tick();

    // two-word frame, latency T+2
    send(8'hA5, 1'b0);
    send(8'h3C, 1'b1);
    chk("f1_t1_valid", 32'(b_valid), 32'h0);
    tick();
    chk("f1_w0_valid", 32'(b_valid), 32'h1);
    chk("f1_w0_data",  32'(b_data),  32'hA5);
    chk("f1_w0_last",  32'(b_last),  32'h0);
    tick();
    chk("f1_w1_data",  32'(b_data),  32'h3C);
    chk("f1_w1_last",  32'(b_last),  32'h1);
    tick();
    chk("f1_end_valid", 32'(b_valid), 32'h0);
    chk("f1_ok",        32'(b_ok),    32'h1);
    chk("f1_fill",      32'(b_fill),  32'h0);

    // single-word frame
    send(8'h7E, 1'b1);
    chk("f2_state_idle", 32'(u_b.state), 32'h0);
    tick();
    chk("f2_valid", 32'(b_valid), 32'h1);
    chk("f2_data",  32'(b_data),  32'h7E);
    chk("f2_last",  32'(b_last),  32'h1);
    tick();
    chk("f2_end_valid", 32'(b_valid), 32'h0);
    chk("f2_ok",        32'(b_ok),    32'h2);

    // oversized frame (MAX_FRAME=4), drop on 5th word
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 1'b0);
      chk("f3_pre_dp", 32'(b_dp), 32'h0);
    end
    chk("f3_fill4", 32'(b_fill), 32'h4);
    send(8'h05, 1'b0);
    chk("f3_dp",    32'(b_dp),   32'h1);
    chk("f3_drop",  32'(b_drop), 32'h1);
    chk("f3_fill0", 32'(b_fill), 32'h0);
    send(8'h06, 1'b1);
    chk("f3_dp_clr",  32'(b_dp),    32'h0);
    chk("f3_valid_a", 32'(b_valid), 32'h0);
    tick(); tick();
    chk("f3_valid_b", 32'(b_valid), 32'h0);
    chk("f3_drop_hold", 32'(b_drop), 32'h1);
    chk("f3_ok_hold",   32'(b_ok),   32'h2);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    tick();
    chk("f3b_w0_data", 32'(b_data), 32'h11);
    chk("f3b_w0_last", 32'(b_last), 32'h0);
    tick();
    chk("f3b_w1_data", 32'(b_data), 32'h22);
    chk("f3b_w1_last", 32'(b_last), 32'h1);
    tick();
    chk("f3b_end_valid", 32'(b_valid), 32'h0);
    chk("f3b_ok",        32'(b_ok),    32'h3);

    // timeout with a committed frame pending behind a stalled consumer
    rdy_b = 1'b0;
    send(8'h31, 1'b0);
    send(8'h32, 1'b1);
    tick();
    chk("f4_pend_data", 32'(b_data), 32'h31);
    chk("f4_pend_fill", 32'(b_fill), 32'h1);
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    chk("f4_fill4", 32'(b_fill), 32'h4);
    repeat (7) tick();
    chk("f4_pre_dp",   32'(b_dp),   32'h0);
    chk("f4_pre_fill", 32'(b_fill), 32'h4);
    tick();
    chk("f4_dp",    32'(b_dp),   32'h1);
    chk("f4_fill1", 32'(b_fill), 32'h1);
    chk("f4_drop",  32'(b_drop), 32'h2);
    rdy_b = 1'b1;
    chk("f4_w0_data", 32'(b_data), 32'h31);
    tick();
    chk("f4_w1_data", 32'(b_data), 32'h32);
    chk("f4_w1_last", 32'(b_last), 32'h1);
    tick();
    chk("f4_end_valid", 32'(b_valid), 32'h0);
    send(8'h51, 1'b0);
    send(8'h52, 1'b1);
    tick();
    chk("f4b_w0_data", 32'(b_data), 32'h51);
    tick();
    chk("f4b_w1_data", 32'(b_data), 32'h52);
    chk("f4b_w1_last", 32'(b_last), 32'h1);
    chk("f4b_ok",      32'(b_ok),   32'h5);

    // full buffer on instance A (DEPTH=8)
    sel_b = 1'b0;
    rdy_a = 1'b0;
    for (int i = 0; i < 7; i++) send(8'h80 + 8'(i), 1'b0);
    send(8'h87, 1'b1);
    chk("f5_fill8",  32'(a_fill),  32'h8);
    chk("f5_valid0", 32'(a_valid), 32'h0);
    send(8'h90, 1'b0);
    chk("f5_dp",     32'(a_dp),    32'h1);
    chk("f5_drop",   32'(a_drop),  32'h1);
    chk("f5_valid1", 32'(a_valid), 32'h1);
    chk("f5_fill7",  32'(a_fill),  32'h7);
    send(8'h91, 1'b1);
    chk("f5_dp_clr", 32'(a_dp),    32'h0);
    chk("f5_drop1",  32'(a_drop),  32'h1);
    chk("f5_ok",     32'(a_ok),    32'h1);
    rdy_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("f5_drain_valid", 32'(a_valid), 32'h1);
      chk("f5_drain_data",  32'(a_data),  32'h80 + 32'(i));
      chk("f5_drain_last",  32'(a_last),  (i == 7) ? 32'h1 : 32'h0);
      tick();
    end
    chk("f5_end_valid", 32'(a_valid), 32'h0);
    chk("f5_end_fill",  32'(a_fill),  32'h0);

    // reset mid-frame with committed data pending
    rdy_a = 1'b0;
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b1);
    send(8'hD1, 1'b0);
    chk("f6_pre_valid", 32'(a_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("f6_rst_valid", 32'(a_valid), 32'h0);
    chk("f6_rst_fill",  32'(a_fill),  32'h0);
    chk("f6_rst_ok",    32'(a_ok),    32'h0);
    chk("f6_rst_drop",  32'(a_drop),  32'h0);
    chk("f6_rst_data",  32'(a_data),  32'h0);
    tick();
    rst_n = 1'b1;
    rdy_a = 1'b1;
    tick();
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b1);
    chk("f6_t1_valid", 32'(a_valid), 32'h0);
    tick();
    chk("f6_w0_data", 32'(a_data), 32'hE1);
    chk("f6_w0_last", 32'(a_last), 32'h0);
    tick();
    chk("f6_w1_data", 32'(a_data), 32'hE2);
    chk("f6_w1_last", 32'(a_last), 32'h1);
    chk("f6_ok",      32'(a_ok),   32'h1);
    tick();
    chk("f6_end_valid", 32'(a_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
